// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the RAM-port arbiter and the cache controllers:
// grant and burst-state encodings plus the cache-line length.
`define ARB_LINE_WORDS 4

package mem_port_arbiter_pkg;

    // Byte offset of a word inside the byte-addressed RAM space.
    localparam int unsigned ADDR_LSB = 2;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } arb_grant_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_BURST = 2'd1,
        DC_BURST = 2'd2,
        GAP      = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the side that did not win last time
// is chosen; the history register only moves when the grant is taken.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ic_req,
    input  logic       dc_req,
    input  logic       take,
    output logic       grant_valid,
    output arb_grant_t grant
);

    arb_grant_t last_grant_reg;

    // Reset to DC so that the icache wins the very first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= DC;
        end else if (take && grant_valid) begin
            last_grant_reg <= grant;
        end
    end

    always_comb begin
        grant_valid = ic_req | dc_req;
        grant       = IC;
        if (ic_req && dc_req) begin
            grant = (last_grant_reg == IC) ? DC : IC;
        end else if (dc_req) begin
            grant = DC;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-word RAM port between icache refills and dcache
// refill/writeback bursts, returning each beat to the granted side only.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = `ARB_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic [WORD_W-1:0]             ic_word,
    output logic                          ic_word_ready,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [WORD_W-1:0]             dc_wdata,
    output logic [$clog2(LINE_WORDS)-1:0] dc_beat,
    output logic [WORD_W-1:0]             dc_word,
    output logic                          dc_word_ready,
    output logic                          dc_done,
    output logic                          ram_req,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [WORD_W-1:0]             ram_wdata,
    input  logic [WORD_W-1:0]             ram_rdata,
    input  logic                          ram_ack
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((LINE_WORDS << ADDR_LSB) - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    arb_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic              we_reg, we_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic       take;
    logic       grant_valid;
    arb_grant_t grant;
    logic       in_burst;
    logic       last_beat;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .ic_req      (ic_req),
        .dc_req      (dc_req),
        .take        (take),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign in_burst  = (state_reg == IC_BURST) || (state_reg == DC_BURST);
    assign last_beat = (cnt_reg == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            we_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            we_reg    <= we_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Base address and direction are captured once at grant, so requester
    // changes mid-burst have no effect.
    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        we_next    = we_reg;
        cnt_next   = cnt_reg;
        take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    take     = 1'b1;
                    cnt_next = '0;
                    if (grant == IC) begin
                        state_next = IC_BURST;
                        base_next  = ic_addr & LINE_MASK;
                        we_next    = 1'b0;
                    end else begin
                        state_next = DC_BURST;
                        base_next  = dc_addr & LINE_MASK;
                        we_next    = dc_we;
                    end
                end
            end
            IC_BURST, DC_BURST: begin
                if (ram_ack) begin
                    if (last_beat) begin
                        state_next = GAP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            GAP: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_req       = in_burst;
        ram_we        = in_burst & we_reg;
        ram_addr      = '0;
        ram_wdata     = '0;
        dc_beat       = cnt_reg;
        ic_word       = '0;
        ic_word_ready = 1'b0;
        ic_done       = 1'b0;
        dc_word       = '0;
        dc_word_ready = 1'b0;
        dc_done       = 1'b0;
        if (in_burst) begin
            ram_addr = base_reg + (ADDR_W'(cnt_reg) << ADDR_LSB);
        end
        if (state_reg == IC_BURST) begin
            ic_word       = ram_rdata;
            ic_word_ready = ram_ack;
            ic_done       = ram_ack & last_beat;
        end
        if (state_reg == DC_BURST) begin
            ram_wdata     = we_reg ? dc_wdata : '0;
            dc_word       = ram_rdata;
            dc_word_ready = ram_ack;
            dc_done       = ram_ack & last_beat;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requesters queue the expected beats of each burst, a
// negedge monitor checks every ready/done the arbiter presents.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        done;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic [31:0] ic_word;
    logic        ic_word_ready, ic_done;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata;
    logic [1:0]  dc_beat;
    logic [31:0] dc_word;
    logic        dc_word_ready, dc_done;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        model_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic        ram_ack;

    beat_t ic_q[$];
    beat_t dc_q[$];
    logic  gq[$];

    int   checks = 0;
    int   errors = 0;
    logic gap_en = 1'b0;
    int   cyc = 0;
    int   last_done = -100;
    logic prev_req = 1'b0;
    int   dly = 0;

    assign ram_ack  = model_ack | spur_ack;
    assign dc_wdata = 32'hCAFE_0000 | {30'd0, dc_beat};

    mem_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_word       (ic_word),
        .ic_word_ready (ic_word_ready),
        .ic_done       (ic_done),
        .dc_req        (dc_req),
        .dc_we         (dc_we),
        .dc_addr       (dc_addr),
        .dc_wdata      (dc_wdata),
        .dc_beat       (dc_beat),
        .dc_word       (dc_word),
        .dc_word_ready (dc_word_ready),
        .dc_done       (dc_done),
        .ram_req       (ram_req),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .ram_ack       (ram_ack)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic side, input logic [31:0] base, input logic we,
                             input int nbeats, input bit with_done);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.addr  = base + 32'(4 * i);
            b.we    = we;
            b.wdata = we ? (32'hCAFE_0000 | 32'(i)) : 32'h0;
            b.done  = with_done && (i == 3);
            if (side) dc_q.push_back(b);
            else      ic_q.push_back(b);
        end
    endtask

    // One full line burst from one requester; address/we are disturbed after
    // the first beat to show they were latched at grant.
    task automatic burst(input logic side, input logic [31:0] addr, input logic [31:0] base,
                         input logic we, input bit spur_gap);
        int   t;
        logic seen;
        logic scr;
        push_line(side, base, we, 4, 1'b1);
        @(posedge clk); #1;
        if (side) begin dc_req = 1'b1; dc_addr = addr; dc_we = we; end
        else begin ic_req = 1'b1; ic_addr = addr; end
        t = 0; seen = 1'b0; scr = 1'b0;
        while (!seen && t < 60) begin
            @(negedge clk);
            t++;
            seen = side ? dc_done : ic_done;
            if (!scr && (side ? dc_word_ready : ic_word_ready)) begin
                scr = 1'b1;
                if (side) begin dc_addr = 32'hDEAD_BEE0; dc_we = ~we; end
                else ic_addr = 32'hDEAD_BEE0;
            end
        end
        chk(side ? "dc_done_within_30" : "ic_done_within_30", 32'(t <= 30), 32'd1);
        @(posedge clk); #1;
        if (side) dc_req = 1'b0;
        else      ic_req = 1'b0;
        if (spur_gap) begin
            spur_ack = 1'b1;
            @(negedge clk);
            chk("gap_no_ram_req", 32'(ram_req), 32'd0);
            @(posedge clk); #1;
            spur_ack = 1'b0;
        end
    endtask

    task automatic check_beat(input string name, input beat_t e, input logic [31:0] word,
                              input logic done, input logic o_ready, input logic [31:0] o_word,
                              input logic o_done);
        chk({name, "_addr"}, ram_addr, e.addr);
        chk({name, "_we"}, 32'(ram_we), 32'(e.we));
        chk({name, "_wdata"}, ram_wdata, e.wdata);
        chk({name, "_word"}, word, 32'hD000_0000 | e.addr);
        chk({name, "_done"}, 32'(done), 32'(e.done));
        chk({name, "_other_quiet"}, {30'd0, o_ready, o_done}, 32'd0);
        chk({name, "_other_word"}, o_word, 32'd0);
        $display("beat %s addr=0x%0h we=%0d word=0x%0h wdata=0x%0h done=%0d",
                 name, ram_addr, ram_we, word, ram_wdata, done);
    endtask

    // RAM model: acknowledges each beat two cycles after it is requested.
    initial forever begin
        @(posedge clk); #1;
        if (ram_req) begin
            if (dly == 2) begin
                model_ack = 1'b1;
                ram_rdata = 32'hD000_0000 | ram_addr;
                dly = 0;
            end else begin
                model_ack = 1'b0;
                ram_rdata = 32'hBAD0_0000;
                dly++;
            end
        end else begin
            model_ack = 1'b0;
            ram_rdata = 32'hBAD0_0000;
            dly = 0;
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        beat_t e;
        logic  g;
        @(negedge clk);
        cyc++;
        if (ram_req && !prev_req && gap_en && (cyc - last_done) <= 8)
            chk("regrant_gap", 32'(cyc - last_done), 32'd3);
        prev_req = ram_req;
        if (ic_word_ready) begin
            if (ic_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ic_unexpected_ready: got ready at 0x%0h, expected none", ram_addr);
            end else begin
                e = ic_q.pop_front();
                check_beat("ic", e, ic_word, ic_done, dc_word_ready, dc_word, dc_done);
            end
        end
        if (dc_word_ready) begin
            if (dc_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dc_unexpected_ready: got ready at 0x%0h, expected none", ram_addr);
            end else begin
                e = dc_q.pop_front();
                check_beat("dc", e, dc_word, dc_done, ic_word_ready, ic_word, ic_done);
            end
        end
        if (ic_done || dc_done) begin
            last_done = cyc;
            chk("done_has_ready", {30'd0, ic_done & ~ic_word_ready, dc_done & ~dc_word_ready}, 32'd0);
            if (gq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done ic=%0d dc=%0d, expected none", ic_done, dc_done);
            end else begin
                g = gq.pop_front();
                chk("grant_order", 32'(dc_done), 32'(g));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ram_req", 32'(ram_req), 32'd0);
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        chk("reset_ready_done", {28'd0, ic_word_ready, ic_done, dc_word_ready, dc_done}, 32'd0);
        chk("reset_dc_beat", 32'(dc_beat), 32'd0);

        // Simultaneous requests after reset: IC, DC, then alternation.
        gap_en = 1'b1;
        gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
        fork
            begin
                burst(1'b0, 32'h0000_0504, 32'h0000_0500, 1'b0, 1'b0);
                burst(1'b0, 32'h0000_051C, 32'h0000_0510, 1'b0, 1'b0);
            end
            begin
                burst(1'b1, 32'h0000_0604, 32'h0000_0600, 1'b0, 1'b0);
                burst(1'b1, 32'h0000_0628, 32'h0000_0620, 1'b0, 1'b0);
            end
        join
        gap_en = 1'b0;
        repeat (12) @(posedge clk);

        // IC-only refill.
        gq.push_back(1'b0);
        burst(1'b0, 32'h0000_0104, 32'h0000_0100, 1'b0, 1'b0);
        repeat (4) @(posedge clk);

        // DC writeback.
        gq.push_back(1'b1);
        burst(1'b1, 32'h0000_2008, 32'h0000_2000, 1'b1, 1'b0);
        repeat (4) @(posedge clk);

        // Reset during beat 2 of an IC burst: only beats 0 and 1 complete.
        push_line(1'b0, 32'h0000_0300, 1'b0, 2, 1'b0);
        @(posedge clk); #1;
        ic_req = 1'b1; ic_addr = 32'h0000_030C;
        n = 0; t = 0;
        while (n < 2 && t < 60) begin
            @(negedge clk);
            t++;
            if (ic_word_ready) n++;
        end
        chk("rst_test_beats_before_reset", 32'(n), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1; ic_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ram_req", 32'(ram_req), 32'd0);
        chk("rst_mid_dc_beat", 32'(dc_beat), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_mid_stays_idle", 32'(ram_req), 32'd0);
        gq.push_back(1'b0);
        burst(1'b0, 32'h0000_041C, 32'h0000_0410, 1'b0, 1'b0);
        repeat (4) @(posedge clk);

        // Spurious acks in IDLE and GAP.
        @(posedge clk); #1;
        spur_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_quiet", {28'd0, ic_word_ready, ic_done, dc_word_ready, dc_done}, 32'd0);
        chk("idle_ack_ram_req", 32'(ram_req), 32'd0);
        @(posedge clk); #1;
        spur_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_state_kept", 32'(ram_req), 32'd0);
        gq.push_back(1'b0);
        burst(1'b0, 32'h0000_0708, 32'h0000_0700, 1'b0, 1'b1);
        repeat (12) @(posedge clk);

        // Starvation: both sides keep requesting; grants alternate DC/IC.
        gap_en = 1'b1;
        for (int i = 0; i < 20; i++) gq.push_back((i % 2) == 0);
        fork
            begin
                for (int i = 0; i < 10; i++)
                    burst(1'b0, 32'h0000_1008 + 32'(i * 64), 32'h0000_1000 + 32'(i * 64), 1'b0, 1'b0);
            end
            begin
                for (int i = 0; i < 10; i++)
                    burst(1'b1, 32'h0000_3004 + 32'(i * 64), 32'h0000_3000 + 32'(i * 64),
                          1'(i % 2), 1'b0);
            end
        join
        gap_en = 1'b0;

        t = 0;
        while ((ic_q.size() + dc_q.size() + gq.size()) != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("queues_drained", 32'(ic_q.size() + dc_q.size() + gq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
